// File: rtl/fetch_queue_pkg.sv
// Shared widths and entry layout for the fetch queue.
// Used by fetch_queue and fq_ram.
package fetch_queue_pkg;

    localparam int INSN_LEN    = 32;
    localparam int ADDR_LEN    = 32;
    localparam int GSH_BHR_LEN = 10;

    typedef struct packed {
        logic [INSN_LEN-1:0]    inst;
        logic [ADDR_LEN-1:0]    pc;
        logic                   pred;
        logic [GSH_BHR_LEN-1:0] bhr;
    } fq_entry_t;

    function automatic fq_entry_t make_entry(
        input logic [INSN_LEN-1:0]    inst,
        input logic [ADDR_LEN-1:0]    pc,
        input logic                   pred,
        input logic [GSH_BHR_LEN-1:0] bhr
    );
        fq_entry_t e;
        e.inst = inst;
        e.pc   = pc;
        e.pred = pred;
        e.bhr  = bhr;
        return e;
    endfunction

endpackage

// File: rtl/fq_ram.sv
// Fetch queue storage: two write ports (tail, tail+1), two asynchronous read ports (head, head+1).
// Contents are never reset.
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [PTR_W-1:0] waddr0,
    input  fq_entry_t        wdata0,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr1,
    input  fq_entry_t        wdata1,
    input  logic [PTR_W-1:0] raddr0,
    output fq_entry_t        rdata0,
    input  logic [PTR_W-1:0] raddr1,
    output fq_entry_t        rdata1
);

    fq_entry_t mem [DEPTH];

    // Write addresses are always tail and tail+1, so the two ports never collide.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Two-in / two-out instruction queue between fetch and decode, flushed on misprediction.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming group combinationally.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_valid,
    input  logic [ADDR_LEN-1:0]    if_pc,
    input  logic [INSN_LEN-1:0]    if_inst1,
    input  logic [INSN_LEN-1:0]    if_inst2,
    input  logic                   if_invalid2,
    input  logic                   if_predict_cond,
    input  logic [GSH_BHR_LEN-1:0] if_bhr,
    output logic                   if_stall,
    input  logic                   id_stall,
    input  logic                   prmiss,
    output logic                   out_valid1,
    output logic                   out_valid2,
    output logic [INSN_LEN-1:0]    out_inst1,
    output logic [INSN_LEN-1:0]    out_inst2,
    output logic [ADDR_LEN-1:0]    out_pc1,
    output logic [ADDR_LEN-1:0]    out_pc2,
    output logic                   out_pred1,
    output logic                   out_pred2,
    output logic [GSH_BHR_LEN-1:0] out_bhr1,
    output logic [GSH_BHR_LEN-1:0] out_bhr2
);

    localparam logic [PTR_W:0] STALL_LVL = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic       enq;
    logic       bypass;
    logic       wr;
    logic [1:0] enq_n;
    logic [1:0] deq_n;
    logic       ram_valid1;
    logic       ram_valid2;

    fq_entry_t in_e0;
    fq_entry_t in_e1;
    fq_entry_t rd_e0;
    fq_entry_t rd_e1;
    fq_entry_t sel_e0;
    fq_entry_t sel_e1;

    // Stall depends only on registered occupancy, never on this cycle's fetch inputs.
    assign if_stall = (count > STALL_LVL);
    assign enq      = if_valid & ~if_stall & ~prmiss;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = (count == '0) & if_valid & ~prmiss & ~id_stall;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed group is consumed straight from the inputs and never stored.
    assign wr    = enq & ~bypass;
    assign enq_n = wr ? (if_invalid2 ? 2'd1 : 2'd2) : 2'd0;

    // The predicted-taken flag belongs to the last instruction of the group only.
    assign in_e0 = make_entry(if_inst1, if_pc, if_invalid2 & if_predict_cond, if_bhr);
    assign in_e1 = make_entry(if_inst2, if_pc + ADDR_LEN'(4), if_predict_cond, if_bhr);

    fq_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk    (clk),
        .we0    (wr),
        .waddr0 (tail),
        .wdata0 (in_e0),
        .we1    (wr & ~if_invalid2),
        .waddr1 (tail + PTR_W'(1)),
        .wdata1 (in_e1),
        .raddr0 (head),
        .rdata0 (rd_e0),
        .raddr1 (head + PTR_W'(1)),
        .rdata1 (rd_e1)
    );

    assign ram_valid1 = (count >= (PTR_W+1)'(1));
    assign ram_valid2 = (count >= (PTR_W+1)'(2));
    assign deq_n      = id_stall ? 2'd0 : ({1'b0, ram_valid1} + {1'b0, ram_valid2});

    assign sel_e0     = bypass ? in_e0 : rd_e0;
    assign sel_e1     = bypass ? in_e1 : rd_e1;
    assign out_valid1 = bypass ? 1'b1         : ram_valid1;
    assign out_valid2 = bypass ? ~if_invalid2 : ram_valid2;

    assign out_inst1 = sel_e0.inst;
    assign out_pc1   = sel_e0.pc;
    assign out_pred1 = sel_e0.pred;
    assign out_bhr1  = sel_e0.bhr;
    assign out_inst2 = sel_e1.inst;
    assign out_pc2   = sel_e1.pc;
    assign out_pred2 = sel_e1.pred;
    assign out_bhr2  = sel_e1.bhr;

    // A flush discards everything, including this cycle's enqueue and dequeue.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (prmiss) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTR_W'(enq_n);
            head  <= head + PTR_W'(deq_n);
            count <= count + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
        end
    end

endmodule
